// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between N_REQ byte producers,
// with per-requester completion pulses and a watchdog for a stalled transmitter.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TO_W    = 12,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic [N_REQ-1:0]     i_Req,
    input  logic [8*N_REQ-1:0]   i_Byte,
    output logic [N_REQ-1:0]     o_Grant,
    output logic [N_REQ-1:0]     o_Ack,
    output logic                 o_Err,
    output logic [IDW-1:0]       o_Err_Id,
    output logic                 o_Busy,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done
);

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    state_t           state;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   last_id;
    logic [TO_W-1:0]  wdog;
    logic             done_d;

    logic [N_REQ-1:0] req_eff;
    logic [IDW-1:0]   win_id;
    logic             win_vld;
    logic [IDW-1:0]   cand;
    logic             tx_free;
    logic             done_rise;
    logic             timed_out;

    // The requester just acked/aborted is ignored for one cycle so it can drop its request.
    always_comb begin
        req_eff = i_Req;
        if ((o_Ack != '0) || o_Err) begin
            req_eff[id] = 1'b0;
        end
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDW'((32'(last_id) + k) % N_REQ);
            if (!win_vld && req_eff[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    assign tx_free   = !i_Tx_Active && !i_Tx_Done;
    assign done_rise = i_Tx_Done && !done_d;
    assign timed_out = (state != S_IDLE) && (wdog == TO_W'(TIMEOUT));

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state     <= S_IDLE;
            id        <= '0;
            last_id   <= IDW'(N_REQ - 1);
            wdog      <= '0;
            done_d    <= 1'b0;
            o_Grant   <= '0;
            o_Ack     <= '0;
            o_Err     <= 1'b0;
            o_Err_Id  <= '0;
            o_Busy    <= 1'b0;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= '0;
        end else begin
            done_d <= i_Tx_Done;
            o_Ack  <= '0;
            o_Err  <= 1'b0;

            if (timed_out) begin
                o_Err    <= 1'b1;
                o_Err_Id <= id;
                o_Tx_DV  <= 1'b0;
                o_Grant  <= '0;
                o_Busy   <= 1'b0;
                last_id  <= id;
                wdog     <= '0;
                state    <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (win_vld && tx_free) begin
                            id        <= win_id;
                            o_Tx_Byte <= i_Byte[win_id*BYTE_W +: BYTE_W];
                            o_Grant   <= N_REQ'(1) << win_id;
                            o_Tx_DV   <= 1'b1;
                            o_Busy    <= 1'b1;
                            wdog      <= '0;
                            state     <= S_ISSUE;
                        end
                    end
                    // DV must stay up until the transmitter actually starts, it ignores DV in cleanup.
                    S_ISSUE: begin
                        if (i_Tx_Active) begin
                            o_Tx_DV <= 1'b0;
                            wdog    <= '0;
                            state   <= S_SEND;
                        end else begin
                            wdog <= wdog + TO_W'(1);
                        end
                    end
                    // Done is high for two cycles; only its rising edge completes the frame.
                    S_SEND: begin
                        if (done_rise) begin
                            o_Ack[id] <= 1'b1;
                            o_Grant   <= '0;
                            o_Busy    <= 1'b0;
                            last_id   <= id;
                            state     <= S_IDLE;
                        end else begin
                            wdog <= wdog + TO_W'(1);
                        end
                    end
                    default: begin
                        o_Tx_DV <= 1'b0;
                        o_Grant <= '0;
                        o_Busy  <= 1'b0;
                        state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a 4-clocks-per-bit transmitter model, a serial receiver,
// and queues of expected acks, errors and transmitted bytes.
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned IDW     = 2;
    localparam int unsigned TO_W    = 12;
    localparam int unsigned TIMEOUT = 4095;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N_REQ-1:0]   req = '0;
    logic [8*N_REQ-1:0] bytes_in = '0;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   ack;
    logic               err;
    logic [IDW-1:0]     err_id;
    logic               busy;
    logic               tx_dv;
    logic [7:0]         tx_byte;
    logic               tx_active = 1'b0;
    logic               tx_done = 1'b0;
    logic               tx_serial = 1'b1;
    logic               stuck = 1'b0;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    int unsigned exp_ack_q[$];
    int unsigned exp_err_q[$];
    int unsigned exp_byte_q[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N_REQ), .IDW(IDW), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_Clock(clk),
        .i_Reset_n(rst_n),
        .i_Req(req),
        .i_Byte(bytes_in),
        .o_Grant(grant),
        .o_Ack(ack),
        .o_Err(err),
        .o_Err_Id(err_id),
        .o_Busy(busy),
        .o_Tx_DV(tx_dv),
        .o_Tx_Byte(tx_byte),
        .i_Tx_Active(tx_active),
        .i_Tx_Done(tx_done)
    );

    // Transmitter model: start, 8 data bits LSB first, stop, one cleanup cycle; done high for 2 cycles.
    typedef enum logic [2:0] {M_IDLE, M_START, M_DATA, M_STOP, M_CLEAN} m_state_t;
    m_state_t   m_state = M_IDLE;
    logic [1:0] m_cnt = '0;
    logic [2:0] m_bit = '0;
    logic [7:0] m_data = '0;

    always @(posedge clk) begin
        case (m_state)
            M_IDLE: begin
                tx_serial <= 1'b1;
                tx_done   <= 1'b0;
                m_cnt     <= '0;
                m_bit     <= '0;
                if (tx_dv && !stuck) begin
                    tx_active <= 1'b1;
                    m_data    <= tx_byte;
                    m_state   <= M_START;
                end
            end
            M_START: begin
                tx_serial <= 1'b0;
                if (m_cnt != 2'd3) m_cnt <= m_cnt + 2'd1;
                else begin m_cnt <= '0; m_state <= M_DATA; end
            end
            M_DATA: begin
                tx_serial <= m_data[m_bit];
                if (m_cnt != 2'd3) m_cnt <= m_cnt + 2'd1;
                else begin
                    m_cnt <= '0;
                    if (m_bit != 3'd7) m_bit <= m_bit + 3'd1;
                    else begin m_bit <= '0; m_state <= M_STOP; end
                end
            end
            M_STOP: begin
                tx_serial <= 1'b1;
                if (m_cnt != 2'd3) m_cnt <= m_cnt + 2'd1;
                else begin
                    m_cnt     <= '0;
                    tx_done   <= 1'b1;
                    tx_active <= 1'b0;
                    m_state   <= M_CLEAN;
                end
            end
            M_CLEAN: begin
                tx_done <= 1'b1;
                m_state <= M_IDLE;
            end
            default: m_state <= M_IDLE;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned id, input int unsigned b);
        exp_ack_q.push_back(id);
        exp_byte_q.push_back(b);
    endtask

    task automatic wait_grant(input int unsigned bound);
        int unsigned n = 0;
        while (grant == '0 && n < bound) begin tick(); n++; end
        check("grant_seen", 32'(grant != '0), 32'd1);
    endtask

    task automatic wait_ack(input int unsigned bound);
        int unsigned n = 0;
        while (ack == '0 && n < bound) begin tick(); n++; end
        check("ack_seen", 32'(ack != '0), 32'd1);
    endtask

    task automatic wait_err(input int unsigned bound);
        int unsigned n = 0;
        while (!err && n < bound) begin tick(); n++; end
        check("err_seen", 32'(err), 32'd1);
    endtask

    // Scoreboard side: acks, errors and received serial frames are popped against expectations.
    logic        rx_busy = 1'b0;
    int unsigned rx_j = 0;
    logic [7:0]  rx_sh = '0;

    always @(negedge clk) begin
        if (ack != '0) begin
            check("ack_expected", 32'(exp_ack_q.size() != 0), 32'd1);
            if (exp_ack_q.size() != 0) check("ack_id", 32'(ack), 32'd1 << exp_ack_q.pop_front());
        end
        if (err) begin
            check("err_expected", 32'(exp_err_q.size() != 0), 32'd1);
            if (exp_err_q.size() != 0) check("err_id", 32'(err_id), exp_err_q.pop_front());
        end
        if (!rx_busy) begin
            if (tx_serial == 1'b0) begin
                rx_busy = 1'b1;
                rx_j    = 0;
            end
        end else begin
            rx_j++;
            if (rx_j >= 6 && rx_j <= 34 && (rx_j - 6) % 4 == 0) rx_sh = {tx_serial, rx_sh[7:1]};
            if (rx_j == 38) begin
                check("stop_bit", 32'(tx_serial), 32'd1);
                check("frame_expected", 32'(exp_byte_q.size() != 0), 32'd1);
                if (exp_byte_q.size() != 0) check("frame_byte", 32'(rx_sh), exp_byte_q.pop_front());
                rx_busy = 1'b0;
            end
        end
    end

    initial begin
        int unsigned order[5];
        int unsigned n;
        order = '{0, 1, 2, 3, 0};

        // Reset values
        tick(); tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_id", 32'(err_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dv", 32'(tx_dv), 32'd0);
        check("rst_byte", 32'(tx_byte), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request: latency, DV hold until active, one ack
        bytes_in[7:0] = 8'hA5;
        req = 4'b0001;
        push(0, 8'hA5);
        tick();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_dv", 32'(tx_dv), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_byte", 32'(tx_byte), 32'hA5);
        tick();
        check("t1_dv_held", 32'(tx_dv), 32'd1);
        tick();
        check("t1_dv_drop", 32'(tx_dv), 32'd0);
        req = '0;
        wait_ack(200);
        check("t1_ack", 32'(ack), 32'h1);
        tick();
        check("t1_ack_pulse", 32'(ack), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_grant", 32'(grant), 32'd0);

        // Round-robin with all four requesting after a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bytes_in = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) push(order[i], 32'h10 + order[i]);
        for (int i = 0; i < 5; i++) begin
            wait_grant(20);
            check("rr_grant", 32'(grant), 32'd1 << order[i]);
            check("rr_byte", 32'(tx_byte), 32'h10 + order[i]);
            wait_ack(200);
            if (i == 4) req = '0;
        end
        tick();
        check("rr_no_more", 32'(grant), 32'd0);

        // Watchdog: transmitter never goes active
        stuck = 1'b1;
        bytes_in[15:8]  = 8'h21;
        bytes_in[23:16] = 8'h22;
        req = 4'b0110;
        exp_err_q.push_back(1);
        push(2, 8'h22);
        wait_grant(20);
        check("wd_grant", 32'(grant), 32'h2);
        wait_err(TIMEOUT + 100);
        check("wd_err_id", 32'(err_id), 32'd1);
        check("wd_dv", 32'(tx_dv), 32'd0);
        check("wd_grant_clr", 32'(grant), 32'd0);
        check("wd_no_ack", 32'(ack), 32'd0);
        stuck = 1'b0;
        req = 4'b0100;
        tick();
        check("wd_next_grant", 32'(grant), 32'h4);
        check("wd_next_byte", 32'(tx_byte), 32'h22);
        wait_ack(200);
        req = '0;
        tick();

        // Reset in the middle of a frame
        bytes_in[31:24] = 8'h3C;
        req = 4'b1000;
        exp_byte_q.push_back(8'h3C);
        wait_grant(20);
        check("rm_grant", 32'(grant), 32'h8);
        n = 0;
        while (!tx_active && n < 20) begin tick(); n++; end
        repeat (12) tick();
        rst_n = 1'b0;
        bytes_in[7:0] = 8'h5A;
        req = 4'b1001;
        push(0, 8'h5A);
        push(3, 8'h3C);
        tick();
        check("rm_grant0", 32'(grant), 32'd0);
        check("rm_ack0", 32'(ack), 32'd0);
        check("rm_err0", 32'(err), 32'd0);
        check("rm_err_id0", 32'(err_id), 32'd0);
        check("rm_busy0", 32'(busy), 32'd0);
        check("rm_dv0", 32'(tx_dv), 32'd0);
        check("rm_byte0", 32'(tx_byte), 32'd0);
        rst_n = 1'b1;
        n = 0;
        while ((tx_active || tx_done) && n < 100) begin
            check("rm_wait_free", 32'(grant), 32'd0);
            tick();
            n++;
        end
        check("rm_tx_free", 32'(tx_active || tx_done), 32'd0);
        tick();
        check("rm_first_grant", 32'(grant), 32'h1);
        wait_ack(200);
        req = 4'b1000;
        wait_grant(20);
        check("rm_second_grant", 32'(grant), 32'h8);
        wait_ack(200);
        req = '0;
        tick();

        // Request drops and byte changes after grant
        bytes_in[23:16] = 8'h6B;
        req = 4'b0100;
        push(2, 8'h6B);
        wait_grant(20);
        check("dr_grant", 32'(grant), 32'h4);
        req = '0;
        bytes_in[23:16] = 8'hFF;
        tick(); tick();
        check("dr_byte_stable", 32'(tx_byte), 32'h6B);
        wait_ack(200);
        tick();

        // Lone requester keeps asserting past its ack
        bytes_in[15:8] = 8'h77;
        req = 4'b0010;
        push(1, 8'h77);
        wait_grant(20);
        check("lr_grant", 32'(grant), 32'h2);
        wait_ack(200);
        bytes_in[15:8] = 8'h78;
        push(1, 8'h78);
        tick();
        check("lr_ack_cycle_grant", 32'(grant), 32'd0);
        tick();
        check("lr_regrant", 32'(grant), 32'h2);
        check("lr_regrant_byte", 32'(tx_byte), 32'h78);
        req = '0;
        wait_ack(200);
        tick();
        check("lr_idle", 32'(busy), 32'd0);

        repeat (50) tick();
        check("left_acks", 32'(exp_ack_q.size()), 32'd0);
        check("left_errs", 32'(exp_err_q.size()), 32'd0);
        check("left_frames", 32'(exp_byte_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
